// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : seven_seg_pkg                                                   |
// | Purpose  : Shared constants and types for the seven-segment scanner.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {A,B,C,D,E,F,G}; element 15 listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
    } digit_entry_t;

endpackage
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_decoder                                                     |
// | Purpose  : Hex nibble to active-low seven-segment pattern.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_scan                                                  |
// | Purpose  : Time-multiplexed driver for NUM_DIGITS hex digits with DP.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
)
(
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  wr_en,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] wr_addr,
    input  logic [3:0]                                            wr_data,
    input  logic                                                  wr_dp,
    input  logic [NUM_DIGITS-1:0]                                 dig_en,
    output logic                                                  A,
    output logic                                                  B,
    output logic                                                  C,
    output logic                                                  D,
    output logic                                                  E,
    output logic                                                  F,
    output logic                                                  G,
    output logic                                                  DP,
    output logic [NUM_DIGITS-1:0]                                 AN
);

    localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);

    localparam logic [CW-1:0] c_TICK = CW'(REFRESH_DIV - 1);
    localparam logic [AW-1:0] c_LAST = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   c_NUM  = (AW + 1)'(NUM_DIGITS);

    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 16)) begin : g_bad_num_digits
        $error("seven_seg_scan: NUM_DIGITS must be in 1..16");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seven_seg_scan: REFRESH_DIV must be >= 2");
    end

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    digit_entry_t          mem_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  w_tick;
    logic                  w_wr_ok;
    logic [NUM_DIGITS-1:0] w_sel;
    logic                  w_on;
    logic [6:0]            w_seg;

    assign w_tick  = (cnt_q == c_TICK);
    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_NUM);

    seg_decoder u_dec (
        .hex_i (mem_q[idx_q].value),
        .seg_o (w_seg)
    );

    always_comb begin
        cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == c_LAST) ? '0 : idx_q + 1'b1;
        end

        // A disabled slot still occupies its time but drives nothing.
        w_sel = NUM_DIGITS'(1) << idx_q;
        w_on  = |(w_sel & dig_en);
        an_d  = ~(w_sel & dig_en);
        seg_d = w_on ? w_seg : SEG_OFF;
        dp_d  = w_on ? ~mem_q[idx_q].dp : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            mem_q[wr_addr] <= '{value: wr_data, dp: wr_dp};
        end
    end

    assign {A, B, C, D, E, F, G} = seg_q;
    assign DP = dp_q;
    assign AN = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seven_seg_scan                                               |
// | Purpose  : Self-checking bench: decode table, scan model, reset corners.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic [3:0] dig_en = 4'hF;
    logic       A, B, C, D, E, F, G, DP;
    logic [3:0] AN;

    logic       wr_en1 = 1'b0;
    logic [0:0] wr_addr1 = '0;
    logic [3:0] wr_data1 = '0;
    logic       wr_dp1 = 1'b0;
    logic [0:0] dig_en1 = 1'b1;
    logic       A1, B1, C1, D1, E1, F1, G1, DP1;
    logic [0:0] AN1;

    wire [6:0] seg  = {A, B, C, D, E, F, G};
    wire [6:0] seg1 = {A1, B1, C1, D1, E1, F1, G1};

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .dig_en(dig_en),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .DP(DP), .AN(AN)
    );

    seven_seg_scan #(.NUM_DIGITS(1), .REFRESH_DIV(RD)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .wr_dp(wr_dp1), .dig_en(dig_en1),
        .A(A1), .B(B1), .C(C1), .D(D1), .E(E1), .F(F1), .G(G1), .DP(DP1), .AN(AN1)
    );

    typedef struct {
        logic [3:0] hex;
        logic       dp;
        logic [6:0] seg;
        logic       dpo;
    } vec_t;

    logic [6:0] ref_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: contents plus number of edges since reset release.
    logic [3:0] m_val [ND];
    logic       m_dp  [ND];
    int         m_edges;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_val[i] = '0;
            m_dp[i]  = 1'b0;
        end
        m_edges = 0;
    endtask

    // One clock edge of the 4-digit DUT checked against the model.
    task automatic cycle();
        int         slot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        slot = (m_edges / RD) % ND;
        if (dig_en[slot]) begin
            exp_an  = ~(4'b0001 << slot);
            exp_seg = ref_tab[m_val[slot]];
            exp_dp  = ~m_dp[slot];
        end else begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end
        if (wr_en) begin
            m_val[wr_addr] = wr_data;
            m_dp[wr_addr]  = wr_dp;
        end
        @(posedge clk);
        m_edges++;
        #1;
        check("scan_AN",  32'(AN),  32'(exp_an));
        check("scan_SEG", 32'(seg), 32'(exp_seg));
        check("scan_DP",  32'(DP),  32'(exp_dp));
    endtask

    initial begin
        vec_t vecs [16];
        int   cnt;
        int   guard;
        int   slot;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{hex: 4'(i), dp: 1'(i), seg: ref_tab[i], dpo: ~1'(i)};
        end

        // Reset held with clock running.
        repeat (3) @(posedge clk);
        #1;
        check("rst_AN",  32'(AN),  32'hF);
        check("rst_SEG", 32'(seg), 32'h7F);
        check("rst_DP",  32'(DP),  32'h1);
        check("rst_AN1", 32'(AN1), 32'h1);
        rst_n = 1'b1;

        // Decode sweep on the single-digit instance.
        for (int i = 0; i < 16; i++) begin
            wr_en1   = 1'b1;
            wr_addr1 = 1'b0;
            wr_data1 = vecs[i].hex;
            wr_dp1   = vecs[i].dp;
            @(posedge clk);
            #1;
            wr_en1 = 1'b0;
            @(posedge clk);
            #1;
            check("dec_SEG", 32'(seg1), 32'(vecs[i].seg));
            check("dec_DP",  32'(DP1),  32'(vecs[i].dpo));
            check("dec_AN",  32'(AN1),  32'h0);
        end

        // Out-of-range address must leave entry 0 (F, dp lit) untouched.
        wr_en1   = 1'b1;
        wr_addr1 = 1'b1;
        wr_data1 = 4'h8;
        wr_dp1   = 1'b0;
        @(posedge clk);
        #1;
        wr_en1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("badaddr_SEG", 32'(seg1), 32'(ref_tab[15]));
        check("badaddr_DP",  32'(DP1),  32'h0);

        // Fresh reset for the 4-digit scan tests.
        rst_n = 1'b0;
        #1;
        check("rst2_AN", 32'(AN), 32'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        dig_en = 4'hF;
        cycle();
        check("first_AN", 32'(AN), 32'hE);

        // Load 1,2,3,4 and watch two full scan rounds.
        for (int i = 0; i < ND; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = 4'(i + 1);
            wr_dp   = 1'b0;
            cycle();
        end
        wr_en = 1'b0;
        repeat (32) cycle();

        // Live write to the digit currently on display.
        guard = 0;
        while ((m_edges % RD) != 0 && guard < 16) begin
            cycle();
            guard++;
        end
        slot    = (m_edges / RD) % ND;
        wr_en   = 1'b1;
        wr_addr = 2'(slot);
        wr_data = 4'h8;
        wr_dp   = 1'b1;
        cycle();
        wr_en = 1'b0;
        cycle();
        check("live_SEG", 32'(seg), 32'h00);
        check("live_DP",  32'(DP),  32'h0);

        // Blanking of slot 2 over one aligned scan period.
        dig_en = 4'b1011;
        guard = 0;
        while ((m_edges % (RD * ND)) != 0 && guard < 32) begin
            cycle();
            guard++;
        end
        cnt = 0;
        for (int i = 0; i < RD * ND; i++) begin
            cycle();
            if (AN == 4'hF && seg == 7'h7F) cnt++;
        end
        check("blank_len", 32'(cnt), 32'(RD));

        // Reset in the middle of slot 2.
        dig_en = 4'hF;
        guard = 0;
        while (((m_edges / RD) % ND) != 2 && guard < 32) begin
            cycle();
            guard++;
        end
        cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_AN",  32'(AN),  32'hF);
        check("midrst_SEG", 32'(seg), 32'h7F);
        check("midrst_DP",  32'(DP),  32'h1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < RD + 1; i++) begin
            cycle();
            if (AN == 4'hE && seg == 7'b0000001) cnt++;
        end
        check("midrst_slot0", 32'(cnt), 32'(RD));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 4'($urandom_range(0, 15));
            wr_dp   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) dig_en = 4'($urandom_range(0, 15));
            cycle();
        end
        wr_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
